// File: rtl/sap1_defs_pkg.sv
// Shared SAP-1 definitions: opcodes, control-word bit positions and masks.
// Used by the control sequencer, the datapath and the benches.
package sap1_defs_pkg;

  localparam int CTRL_W = 16;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  function automatic ctrl_t cbit(input int idx);
    cbit = ctrl_t'(1) << idx;
  endfunction

  localparam ctrl_t C_HLT = cbit(B_HLT);
  localparam ctrl_t C_MI  = cbit(B_MI);
  localparam ctrl_t C_RI  = cbit(B_RI);
  localparam ctrl_t C_RO  = cbit(B_RO);
  localparam ctrl_t C_IO  = cbit(B_IO);
  localparam ctrl_t C_II  = cbit(B_II);
  localparam ctrl_t C_AI  = cbit(B_AI);
  localparam ctrl_t C_AO  = cbit(B_AO);
  localparam ctrl_t C_EO  = cbit(B_EO);
  localparam ctrl_t C_SU  = cbit(B_SU);
  localparam ctrl_t C_BI  = cbit(B_BI);
  localparam ctrl_t C_OI  = cbit(B_OI);
  localparam ctrl_t C_CE  = cbit(B_CE);
  localparam ctrl_t C_CO  = cbit(B_CO);
  localparam ctrl_t C_J   = cbit(B_J);
  localparam ctrl_t C_FI  = cbit(B_FI);

  typedef struct packed {
    ctrl_t ctrl;
    logic  adv;
  } ucode_t;

  typedef struct packed {
    logic carry;
    logic zero;
  } flags_t;

endpackage

// File: rtl/control_sequencer_rom.sv
// Combinational microcode table: (opcode, step, flags) -> {control word, end-of-instruction}.
// Zero latency; no state, no backpressure.
module microcode_rom
  import sap1_defs_pkg::*;
#(
  parameter int INSTRUCTION_STEPS = 8,
  localparam int STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
) (
  input  logic [3:0]            opcode,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  carry,
  input  logic                  zero,
  output ucode_t                word
);

  localparam logic [STEP_WIDTH-1:0] S0 = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] S1 = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] S2 = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] S3 = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] S4 = STEP_WIDTH'(4);

  ctrl_t ctrl;
  logic  adv;

  always_comb begin
    ctrl = '0;
    adv  = 1'b0;
    if (step == S0) begin
      ctrl = C_CO | C_MI;
    end else if (step == S1) begin
      ctrl = C_RO | C_II | C_CE;
    end else begin
      // Past fetch, adv defaults high: it covers both the final step of each
      // opcode and any stray step beyond it, which must return to fetch.
      adv = 1'b1;
      case (opcode)
        OP_LDA: begin
          if (step == S2) begin
            ctrl = C_IO | C_MI;
            adv  = 1'b0;
          end else if (step == S3) begin
            ctrl = C_RO | C_AI;
          end
        end
        OP_ADD, OP_SUB: begin
          if (step == S2) begin
            ctrl = C_IO | C_MI;
            adv  = 1'b0;
          end else if (step == S3) begin
            ctrl = C_RO | C_BI;
            adv  = 1'b0;
          end else if (step == S4) begin
            ctrl = C_EO | C_AI | C_FI | ((opcode == OP_SUB) ? C_SU : ctrl_t'(0));
          end
        end
        OP_STA: begin
          if (step == S2) begin
            ctrl = C_IO | C_MI;
            adv  = 1'b0;
          end else if (step == S3) begin
            ctrl = C_AO | C_RI;
          end
        end
        OP_LDI: begin
          if (step == S2) ctrl = C_IO | C_AI;
        end
        OP_JMP: begin
          if (step == S2) ctrl = C_IO | C_J;
        end
        OP_JC: begin
          if (step == S2 && carry) ctrl = C_IO | C_J;
        end
        OP_JZ: begin
          if (step == S2 && zero) ctrl = C_IO | C_J;
        end
        OP_OUT: begin
          if (step == S2) ctrl = C_AO | C_OI;
        end
        OP_HLT: begin
          // No adv: the counter parks on s2 until the halt latch takes over.
          if (step == S2) begin
            ctrl = C_HLT;
            adv  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign word = '{ctrl: ctrl, adv: adv};

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control unit: microcode decode plus the flags register and halt latch.
// Control word/adv are combinational from step and opcode; registers update on enabled posedges only.
module control_sequencer
  import sap1_defs_pkg::*;
#(
  parameter int INSTRUCTION_STEPS = 8,
  localparam int STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  mclk_en,
  input  logic [3:0]            i_opcode,
  input  logic [STEP_WIDTH-1:0] i_step,
  input  logic                  i_carry,
  input  logic                  i_zero,
  output logic [CTRL_W-1:0]     o_ctrl,
  output logic                  o_adv,
  output logic                  o_halt,
  output logic [1:0]            o_flags
);

  ucode_t rom_word;
  flags_t flags_q;
  logic   halt_q;
  logic   decode_on;

  microcode_rom #(
    .INSTRUCTION_STEPS(INSTRUCTION_STEPS)
  ) u_rom (
    .opcode(i_opcode),
    .step  (i_step),
    .carry (flags_q.carry),
    .zero  (flags_q.zero),
    .word  (rom_word)
  );

  // Reset and halt both silence the datapath; reset is applied combinationally
  // so the bus is quiet even before any clock edge.
  assign decode_on = rst_n & ~halt_q;

  assign o_ctrl  = decode_on ? rom_word.ctrl : '0;
  assign o_adv   = decode_on & rom_word.adv;
  assign o_halt  = halt_q;
  assign o_flags = flags_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (mclk_en && o_ctrl[B_FI]) begin
      flags_q <= flags_t'({i_carry, i_zero});
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (mclk_en && o_ctrl[B_HLT]) begin
      halt_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: drives opcode/step on negedge and
// checks control word, adv, flags and halt against hand-computed values.
module tb_control_sequencer;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic        mclk_en;
  logic [3:0]  i_opcode;
  logic [2:0]  i_step;
  logic        i_carry;
  logic        i_zero;
  logic [15:0] o_ctrl;
  logic        o_adv;
  logic        o_halt;
  logic [1:0]  o_flags;

  int tests = 0;
  int fails = 0;

  control_sequencer #(.INSTRUCTION_STEPS(8)) dut (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .mclk_en (mclk_en),
    .i_opcode(i_opcode),
    .i_step  (i_step),
    .i_carry (i_carry),
    .i_zero  (i_zero),
    .o_ctrl  (o_ctrl),
    .o_adv   (o_adv),
    .o_halt  (o_halt),
    .o_flags (o_flags)
  );

  always #5 mclk = ~mclk;

  // Present a new opcode/step just after negedge, then settle before checking.
  task automatic drive(input logic [3:0] op, input logic [2:0] st);
    @(negedge mclk);
    i_opcode = op;
    i_step   = st;
    #2;
  endtask

  task automatic after_posedge();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [15:0] exp_ctrl, input logic exp_adv);
    tests++;
    if (o_ctrl !== exp_ctrl) begin
      fails++;
      $display("FAIL %s ctrl: got %04h expected %04h", name, o_ctrl, exp_ctrl);
    end
    tests++;
    if (o_adv !== exp_adv) begin
      fails++;
      $display("FAIL %s adv: got %b expected %b", name, o_adv, exp_adv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mclk_en = 1'b1; i_opcode = 4'h2; i_step = 3'd3;
    i_carry = 1'b0; i_zero = 1'b0;
    #3 rst_n = 1'b0;
    #20;
    chk_word("reset_hold", 16'h0000, 1'b0);
    tests++;
    if (o_flags !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b expected 00", o_flags); end
    tests++;
    if (o_halt !== 1'b0) begin fails++; $display("FAIL reset_halt: got %b expected 0", o_halt); end
    @(negedge mclk);
    i_opcode = 4'h2; i_step = 3'd0; rst_n = 1'b1;
    #2;
    chk_word("reset_release_s0", 16'h4004, 1'b0);
  endtask

  task automatic test_add();
    i_carry = 1'b1; i_zero = 1'b0;
    drive(4'h2, 3'd0); chk_word("add_s0", 16'h4004, 1'b0);
    drive(4'h2, 3'd1); chk_word("add_s1", 16'h1408, 1'b0);
    drive(4'h2, 3'd2); chk_word("add_s2", 16'h4800, 1'b0);
    drive(4'h2, 3'd3); chk_word("add_s3", 16'h1020, 1'b0);
    tests++;
    if (o_flags !== 2'b00) begin fails++; $display("FAIL add_flags_pre: got %b expected 00", o_flags); end
    drive(4'h2, 3'd4); chk_word("add_s4", 16'h0281, 1'b1);
    after_posedge();
    tests++;
    if (o_flags !== 2'b10) begin fails++; $display("FAIL add_flags_post: got %b expected 10", o_flags); end
    drive(4'h3, 3'd4); chk_word("sub_s4", 16'h02C1, 1'b1);
  endtask

  task automatic test_reset_mid_add();
    drive(4'h2, 3'd0);
    drive(4'h2, 3'd1);
    drive(4'h2, 3'd2);
    drive(4'h2, 3'd3);
    rst_n = 1'b0;
    #1;
    chk_word("midreset", 16'h0000, 1'b0);
    tests++;
    if (o_flags !== 2'b00) begin fails++; $display("FAIL midreset_flags: got %b expected 00", o_flags); end
    tests++;
    if (o_halt !== 1'b0) begin fails++; $display("FAIL midreset_halt: got %b expected 0", o_halt); end
    @(negedge mclk);
    i_step = 3'd0; rst_n = 1'b1;
    #2;
    chk_word("midreset_release", 16'h4004, 1'b0);
  endtask

  task automatic test_cond_jump();
    drive(4'h7, 3'd2); chk_word("jc_nc", 16'h0000, 1'b1);
    drive(4'h8, 3'd2); chk_word("jz_nz", 16'h0000, 1'b1);
    i_carry = 1'b1; i_zero = 1'b1;
    drive(4'h2, 3'd4);
    after_posedge();
    tests++;
    if (o_flags !== 2'b11) begin fails++; $display("FAIL jump_flags: got %b expected 11", o_flags); end
    drive(4'h7, 3'd2); chk_word("jc_c", 16'h0802, 1'b1);
    drive(4'h8, 3'd2); chk_word("jz_z", 16'h0802, 1'b1);
  endtask

  // Walk every non-halting opcode through its slot; adv only on its last step.
  task automatic test_lengths();
    logic [3:0] ops  [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'h9, 4'hD};
    int         lens [12] = '{3, 4, 5, 5, 4, 3, 3, 3, 3, 3, 3, 3};
    i_carry = 1'b0; i_zero = 1'b0;
    for (int k = 0; k < 12; k++) begin
      for (int s = 0; s < lens[k]; s++) begin
        drive(ops[k], 3'(s));
        tests++;
        if (o_adv !== (s == lens[k] - 1)) begin
          fails++;
          $display("FAIL len op=%h s=%0d adv: got %b expected %b", ops[k], s, o_adv, (s == lens[k] - 1));
        end
      end
    end
  endtask

  task automatic test_recovery();
    logic [3:0] ops [5] = '{4'h1, 4'h2, 4'h5, 4'hE, 4'hF};
    drive(4'hA, 3'd2); chk_word("undef_a_s2", 16'h0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(ops[k], 3'd7);
      chk_word("step7", 16'h0000, 1'b1);
    end
    drive(4'h3, 3'd6); chk_word("sub_s6", 16'h0000, 1'b1);
    tests++;
    if (o_halt !== 1'b0) begin fails++; $display("FAIL hlt_s7_nohalt: got %b expected 0", o_halt); end
  endtask

  task automatic test_enable_low();
    i_carry = 1'b0; i_zero = 1'b0;
    drive(4'h2, 3'd4);
    after_posedge();
    mclk_en = 1'b0;
    i_carry = 1'b1; i_zero = 1'b1;
    drive(4'h2, 3'd4); chk_word("en0_add_s4", 16'h0281, 1'b1);
    after_posedge();
    tests++;
    if (o_flags !== 2'b00) begin fails++; $display("FAIL en0_flags: got %b expected 00", o_flags); end
    drive(4'hF, 3'd2); chk_word("en0_hlt_s2", 16'h8000, 1'b0);
    after_posedge();
    tests++;
    if (o_halt !== 1'b0) begin fails++; $display("FAIL en0_halt: got %b expected 0", o_halt); end
    mclk_en = 1'b1;
  endtask

  task automatic test_halt();
    drive(4'hF, 3'd0); chk_word("hlt_s0", 16'h4004, 1'b0);
    drive(4'hF, 3'd1); chk_word("hlt_s1", 16'h1408, 1'b0);
    drive(4'hF, 3'd2); chk_word("hlt_s2", 16'h8000, 1'b0);
    tests++;
    if (o_halt !== 1'b0) begin fails++; $display("FAIL hlt_pre: got %b expected 0", o_halt); end
    after_posedge();
    tests++;
    if (o_halt !== 1'b1) begin fails++; $display("FAIL hlt_post: got %b expected 1", o_halt); end
    chk_word("hlt_post", 16'h0000, 1'b0);
    // Halted: nothing decodes, flags cannot move even on an ADD s4.
    i_carry = 1'b1; i_zero = 1'b0;
    for (int c = 0; c < 22; c++) begin
      drive((c % 2 == 0) ? 4'h2 : 4'hF, (c % 3 == 0) ? 3'd4 : 3'd2);
      tests++;
      if (o_ctrl !== 16'h0000 || o_adv !== 1'b0 || o_halt !== 1'b1) begin
        fails++;
        $display("FAIL halted c=%0d: got ctrl=%04h adv=%b halt=%b expected 0000/0/1", c, o_ctrl, o_adv, o_halt);
      end
    end
    tests++;
    if (o_flags !== 2'b00) begin fails++; $display("FAIL halted_flags: got %b expected 00", o_flags); end
    @(negedge mclk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    i_opcode = 4'h1; i_step = 3'd0;
    #1;
    tests++;
    if (o_halt !== 1'b0) begin fails++; $display("FAIL hlt_cleared: got %b expected 0", o_halt); end
    chk_word("hlt_cleared_s0", 16'h4004, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_reset_mid_add();
    test_cond_jump();
    test_lengths();
    test_recovery();
    test_enable_low();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
